// File: rtl/signal_distributor_pkg.sv
// Shared selector codes and default word width for the signal distributor.
package signal_distributor_pkg;
   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      SEL_CH0 = 2'b00,
      SEL_CH1 = 2'b01,
      SEL_CH2 = 2'b10,
      SEL_ERR = 2'b11
   } sel_e;
endpackage

// File: rtl/signal_distributor_slot.sv
// One-word valid/ready holding register: load, drain, or load and drain in the same cycle.
module dist_slot
   import signal_distributor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             drain_ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // A load wins over a drain, so load+drain keeps the slot full with the new word.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_q && drain_ready_i) begin
         valid_d = 1'b0;
      end
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = load_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

// File: rtl/signal_distributor.sv
// Steers one input word stream to three independently buffered channels; sel 11 words are dropped and counted.
module signal_distributor
   import signal_distributor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int ERRW  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic [2:0]       out_valid,
   input  logic [2:0]       out_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic             err_pulse,
   output logic [ERRW-1:0]  err_count
);
   logic             accept;
   logic             err_accept;
   logic [2:0]       load;
   logic [WIDTH-1:0] slot_data [3];
   logic             err_pulse_q, err_pulse_d;
   logic [ERRW-1:0]  err_count_q, err_count_d;

   // in_ready depends only on the addressed slot, never on in_valid.
   always_comb begin
      in_ready = 1'b1;
      case (in_sel)
         SEL_CH0: in_ready = !out_valid[0] || out_ready[0];
         SEL_CH1: in_ready = !out_valid[1] || out_ready[1];
         SEL_CH2: in_ready = !out_valid[2] || out_ready[2];
         default: in_ready = 1'b1;
      endcase
   end

   assign accept     = in_valid && in_ready;
   assign err_accept = accept && (in_sel == SEL_ERR);

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_slot
         assign load[gi] = accept && (in_sel == 2'(gi));

         dist_slot #(.WIDTH(WIDTH)) u_slot (
            .clk           (clk),
            .rst_n         (rst_n),
            .load_i        (load[gi]),
            .load_data_i   (in_data),
            .drain_ready_i (out_ready[gi]),
            .valid_o       (out_valid[gi]),
            .data_o        (slot_data[gi])
         );
      end
   endgenerate

   assign out_data0 = slot_data[0];
   assign out_data1 = slot_data[1];
   assign out_data2 = slot_data[2];

   always_comb begin
      err_pulse_d = err_accept;
      err_count_d = err_count_q;
      if (err_accept && (err_count_q != {ERRW{1'b1}})) begin
         err_count_d = err_count_q + ERRW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
endmodule

// File: tb/tb_signal_distributor.sv
// Directed bench for signal_distributor: reset, routing, errors, backpressure, full rate, async reset mid-stall.
module tb_signal_distributor;
   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_sel;
   logic [3:0] in_data;
   logic [2:0] out_valid;
   logic [2:0] out_ready;
   logic [3:0] out_data0, out_data1, out_data2;
   logic       err_pulse;
   logic [7:0] err_count;

   int checks   = 0;
   int failures = 0;

   signal_distributor #(.WIDTH(4), .ERRW(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .err_pulse (err_pulse),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Producer protocol: sel must be known whenever a word is offered.
   always @(negedge clk) begin
      if (rst_n && in_valid === 1'b1) begin
         checks++;
         assert (!$isunknown(in_sel)) else begin
            failures++;
            $error("FAIL sel_known observed=%0h expected=known", in_sel);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 2'b00;
      in_data   = 4'b0001;
      out_ready = 3'b111;

      // Reset with stimulus active
      #3;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_data0", 32'(out_data0), 32'h0);
      check("rst_err_pulse", 32'(err_pulse), 32'h0);
      check("rst_err_count", 32'(err_count), 32'h0);
      tick();
      check("rst_hold_valid", 32'(out_valid), 32'h0);
      rst_n = 1'b1;
      check("pre_accept_ready", 32'(in_ready), 32'h1);
      check("pre_accept_valid", 32'(out_valid), 32'h0);

      // Routing: back-to-back to ch0, ch1, ch2
      tick();
      check("r0_valid", 32'(out_valid), 32'h1);
      check("r0_data0", 32'(out_data0), 32'h1);
      in_sel = 2'b01; in_data = 4'b0010;
      check("r1_ready", 32'(in_ready), 32'h1);
      tick();
      check("r1_valid", 32'(out_valid), 32'h2);
      check("r1_data1", 32'(out_data1), 32'h2);
      in_sel = 2'b10; in_data = 4'b0011;
      check("r2_ready", 32'(in_ready), 32'h1);
      tick();
      check("r2_valid", 32'(out_valid), 32'h4);
      check("r2_data2", 32'(out_data2), 32'h3);
      check("r2_data0_hold", 32'(out_data0), 32'h1);
      in_valid = 1'b0;
      tick();
      check("drain_valid", 32'(out_valid), 32'h0);
      check("drain_data2_hold", 32'(out_data2), 32'h3);

      // Error word
      in_valid = 1'b1; in_sel = 2'b11; in_data = 4'b0100;
      check("err_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      check("err_pulse_hi", 32'(err_pulse), 32'h1);
      check("err_count_1", 32'(err_count), 32'h1);
      check("err_valid_same", 32'(out_valid), 32'h0);
      tick();
      check("err_pulse_lo", 32'(err_pulse), 32'h0);
      check("err_count_hold", 32'(err_count), 32'h1);

      // 260 further errors: saturate at 255
      in_valid = 1'b1;
      repeat (253) tick();
      check("err_count_254", 32'(err_count), 32'd254);
      repeat (7) tick();
      check("err_count_sat", 32'(err_count), 32'd255);
      check("err_pulse_sat", 32'(err_pulse), 32'h1);
      in_valid = 1'b0;
      tick();
      check("err_pulse_sat_lo", 32'(err_pulse), 32'h0);
      check("err_count_sat_hold", 32'(err_count), 32'd255);

      // Backpressure on ch1, ch2 unaffected
      out_ready = 3'b101;
      in_valid = 1'b1; in_sel = 2'b01; in_data = 4'b0010;
      tick();
      in_sel = 2'b10; in_data = 4'b0011;
      check("bp_valid_a", 32'(out_valid), 32'h2);
      check("bp_data1_a", 32'(out_data1), 32'h2);
      check("bp_ready_ch2", 32'(in_ready), 32'h1);
      tick();
      in_sel = 2'b01; in_data = 4'b0101;
      check("bp_valid_b", 32'(out_valid), 32'h6);
      check("bp_data2", 32'(out_data2), 32'h3);
      check("bp_ready_stall", 32'(in_ready), 32'h0);
      tick();
      check("bp_valid_c", 32'(out_valid), 32'h2);
      check("bp_data1_stall", 32'(out_data1), 32'h2);
      check("bp_ready_stall2", 32'(in_ready), 32'h0);
      out_ready = 3'b111;
      check("bp_ready_release", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      check("bp_valid_swap", 32'(out_valid), 32'h2);
      check("bp_data1_swap", 32'(out_data1), 32'h5);
      tick();
      check("bp_valid_empty", 32'(out_valid), 32'h0);
      check("bp_data1_hold", 32'(out_data1), 32'h5);

      // Full rate on ch0
      out_ready = 3'b001;
      in_valid = 1'b1; in_sel = 2'b00; in_data = 4'd0;
      for (int k = 0; k < 16; k++) begin
         check($sformatf("fr_ready_%0d", k), 32'(in_ready), 32'h1);
         tick();
         check($sformatf("fr_valid_%0d", k), 32'(out_valid), 32'h1);
         check($sformatf("fr_data_%0d", k), 32'(out_data0), 32'(k));
         in_data = 4'(k + 1);
      end
      in_valid = 1'b0;
      tick();
      check("fr_empty", 32'(out_valid), 32'h0);

      // Reset mid-stall: ch1 full and stalled, err_count = 3
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst2_count", 32'(err_count), 32'h0);
      out_ready = 3'b000;
      in_valid = 1'b1; in_sel = 2'b01; in_data = 4'b1001;
      tick();
      in_sel = 2'b11;
      repeat (3) tick();
      in_valid = 1'b0;
      check("ms_valid", 32'(out_valid), 32'h2);
      check("ms_data1", 32'(out_data1), 32'h9);
      check("ms_count", 32'(err_count), 32'h3);
      check("ms_pulse", 32'(err_pulse), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ms_rst_valid", 32'(out_valid), 32'h0);
      check("ms_rst_data1", 32'(out_data1), 32'h0);
      check("ms_rst_count", 32'(err_count), 32'h0);
      check("ms_rst_pulse", 32'(err_pulse), 32'h0);
      tick();
      check("ms_rst_hold", 32'(out_valid), 32'h0);
      rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
